// File: rtl/mul2_share_arbiter.sv
// Round-robin arbiter sharing one external W x W multiplier between two requesters.
// Latches the winner's operands, registers the returned product and tags it with the winner id.
module mul2_share_arbiter #(
    parameter int unsigned W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             ack0,
    output logic             ack1,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_z,
    output logic [2*W-1:0]   z_out,
    output logic             z_valid,
    output logic             z_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;
    logic [2*W-1:0]   z_out_q, z_out_d;
    logic             z_valid_q, z_valid_d;
    logic             z_id_q, z_id_d;
    logic             busy_q, busy_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             grant0, grant1;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0 = req0 && (!req1 || last_q);
        grant1 = req1 && !grant0;
    end

    always_comb begin
        state_d   = state_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        z_out_d   = z_out_q;
        z_valid_d = 1'b0;
        z_id_d    = z_id_q;
        id_d      = id_q;
        last_d    = last_q;
        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    mul_a_d = grant0 ? a0 : a1;
                    mul_b_d = grant0 ? b0 : b1;
                    id_d    = grant1;
                    ack0_d  = grant0;
                    ack1_d  = grant1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                z_out_d   = mul_z;
                z_id_d    = id_q;
                z_valid_d = 1'b1;
                last_d    = id_q;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            z_out_q   <= '0;
            z_valid_q <= 1'b0;
            z_id_q    <= 1'b0;
            busy_q    <= 1'b0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            z_out_q   <= z_out_d;
            z_valid_q <= z_valid_d;
            z_id_q    <= z_id_d;
            busy_q    <= busy_d;
            id_q      <= id_d;
            last_q    <= last_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign z_out   = z_out_q;
    assign z_valid = z_valid_q;
    assign z_id    = z_id_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mul2_share_arbiter.sv
// Bench for mul2_share_arbiter: directed scenarios plus random traffic, checked every cycle
// against a countdown-based transaction model, with a real 2x2 multiplier on the mul_* side.
module tb_mul2_share_arbiter;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic rst, req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic ack0, ack1, z_valid, z_id, busy;
    logic [W-1:0] mul_a, mul_b;
    logic [2*W-1:0] mul_z, z_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: cycles until the block can accept again, last winner, pending op.
    int m_wait = 0;
    bit m_last = 1'b1;
    bit m_id = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic e_ack0 = 1'b0, e_ack1 = 1'b0, e_zv = 1'b0, e_zid = 1'b0, e_busy = 1'b0;
    logic [W-1:0] e_mul_a = '0, e_mul_b = '0;
    logic [2*W-1:0] e_z = '0;

    always #5 clk = ~clk;

    assign mul_z = (2*W)'(mul_a) * (2*W)'(mul_b);

    mul2_share_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .z_out(z_out), .z_valid(z_valid), .z_id(z_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        e_zv   = 1'b0;
        if (rst) begin
            m_wait = 0; m_last = 1'b1;
            e_mul_a = '0; e_mul_b = '0; e_z = '0; e_zid = 1'b0;
        end else if (m_wait == 0) begin
            if (req0 && (!req1 || m_last)) begin
                e_ack0 = 1'b1; m_id = 1'b0; e_mul_a = a0; e_mul_b = b0;
                m_prod = (2*W)'(a0) * (2*W)'(b0); m_wait = 2;
            end else if (req1) begin
                e_ack1 = 1'b1; m_id = 1'b1; e_mul_a = a1; e_mul_b = b1;
                m_prod = (2*W)'(a1) * (2*W)'(b1); m_wait = 2;
            end
        end else if (m_wait == 2) begin
            e_z = m_prod; e_zid = m_id; e_zv = 1'b1; m_last = m_id; m_wait = 1;
        end else begin
            m_wait = 0;
        end
        e_busy = (m_wait != 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ack", 8'({ack1, ack0}), 8'({e_ack1, e_ack0}));
        chk("mul_ab", 8'({mul_a, mul_b}), 8'({e_mul_a, e_mul_b}));
        chk("result", 8'({z_valid, z_id, z_out}), 8'({e_zv, e_zid, e_z}));
        chk("busy", 8'(busy), 8'(e_busy));
        chk("ack_zv_excl", 8'((ack0 | ack1) & z_valid), 8'd0);
    endtask

    logic [3:0] exp_z [3];
    logic       exp_id [3];

    initial begin
        exp_z[0] = 4'd6; exp_z[1] = 4'd3; exp_z[2] = 4'd6;
        exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        a0 = 2'd3; b0 = 2'd3; a1 = 2'd0; b1 = 2'd0;

        // Reset held for two edges with a pending request.
        step();
        step();
        chk("rst_outs", 8'({ack0, ack1, z_valid, z_id, busy}), 8'd0);
        chk("rst_zab", 8'({z_out, mul_a, mul_b}), 8'd0);

        // Single request 3*3.
        rst = 1'b0;
        step();
        chk("single_ack0", 8'(ack0), 8'd1);
        req0 = 1'b0;
        step();
        chk("single_z", 8'({z_valid, z_id, z_out}), 8'b0010_1001);
        step();
        chk("single_zv_drop", 8'(z_valid), 8'd0);

        // Simultaneous requests after a fresh reset: 0, 1, 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; a0 = 2'd2; b0 = 2'd3;
        req1 = 1'b1; a1 = 2'd1; b1 = 2'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rr_grant", 8'({ack1, ack0}), exp_id[k] ? 8'd2 : 8'd1);
            step();
            chk("rr_z", 8'(z_out), 8'(exp_z[k]));
            chk("rr_id", 8'(z_id), 8'(exp_id[k]));
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Exhaustive operand pairs on requester 1.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                req1 = 1'b1; a1 = W'(a); b1 = W'(b);
                step();
                req1 = 1'b0;
                step();
                chk("exh_z", 8'(z_out), 8'(a * b));
                chk("exh_id", 8'(z_id), 8'd1);
                step();
            end
        end

        // Busy lockout: requester 1 rises while requester 0 is being served.
        req0 = 1'b1; a0 = 2'd2; b0 = 2'd1;
        step();
        chk("lock_ack0", 8'(ack0), 8'd1);
        req0 = 1'b0; req1 = 1'b1; a1 = 2'd3; b1 = 2'd1;
        step();
        chk("lock_calc", 8'(ack1), 8'd0);
        step();
        chk("lock_done", 8'(ack1), 8'd0);
        step();
        chk("lock_e3", 8'(ack1), 8'd1);
        req1 = 1'b0;
        step();
        step();
        step();

        // Reset during CALC abandons the op and restores req0 priority.
        req1 = 1'b1; a1 = 2'd3; b1 = 2'd2;
        step();
        req1 = 1'b0; rst = 1'b1;
        step();
        chk("midrst", 8'({z_valid, busy, z_out}), 8'd0);
        rst = 1'b0;
        step();
        chk("midrst_nozv", 8'(z_valid), 8'd0);
        req0 = 1'b1; req1 = 1'b1; a0 = 2'd1; b0 = 2'd1;
        step();
        chk("midrst_grant", 8'({ack1, ack0}), 8'd1);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
